// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared opcodes, state encodings and ALU selects for the multi-cycle control unit
// Purpose: constants and small decode helpers shared by multi_cycle_ctrl and ctrl_decode.
// Ports: none (package).
package cpu_defs_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLTIU = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;

  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_LS = 4'b0010,
    S_MEM    = 4'b0011,
    S_WB_LD  = 4'b0100,
    S_EXE_BR = 4'b0101,
    S_EXE_AL = 4'b0110,
    S_WB_AL  = 4'b0111,
    S_HALT   = 4'b1000
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU_R,
    CL_ALU_I,
    CL_BR,
    CL_LS,
    CL_JMP,
    CL_HALT
  } op_class_e;

  // Undefined opcodes fall into CL_HALT so a corrupt fetch parks the CPU.
  function automatic op_class_e op_class(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLL, OP_SLT: op_class = CL_ALU_R;
      OP_ADDI, OP_ORI, OP_SLTIU:                     op_class = CL_ALU_I;
      OP_BEQ, OP_BNE, OP_BLTZ:                       op_class = CL_BR;
      OP_SW, OP_LW:                                  op_class = CL_LS;
      OP_J, OP_JR, OP_JAL:                           op_class = CL_JMP;
      default:                                       op_class = CL_HALT;
    endcase
  endfunction

  function automatic logic [2:0] alu_sel(input logic [5:0] op);
    case (op)
      OP_SUB:         alu_sel = ALU_SUB;
      OP_SLL:         alu_sel = ALU_SLL;
      OP_OR, OP_ORI:  alu_sel = ALU_OR;
      OP_AND:         alu_sel = ALU_AND;
      OP_SLTIU:       alu_sel = ALU_SLTU;
      OP_SLT:         alu_sel = ALU_SLT;
      default:        alu_sel = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational control-signal decode from state, opcode and ALU flags
// Purpose: maps current FSM state + Op_code + zero/sign to every datapath control.
// Ports: state/Op_code/zero/sign in; PC, IR, regfile, ALU and data-memory controls out.
module ctrl_decode
  import cpu_defs_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] Op_code,
  input  logic       zero,
  input  logic       sign,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       RegWre,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic       mRD,
  output logic       mWR,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp
);

  op_class_e cls;
  logic      taken;

  assign cls = op_class(Op_code);

  always_comb begin
    taken = 1'b0;
    case (Op_code)
      OP_BEQ:  taken = zero;
      OP_BNE:  taken = ~zero;
      OP_BLTZ: taken = sign;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    RegWre    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    PCSrc     = 2'b00;
    ALUOp     = ALU_ADD;
    case (state)
      S_IF: begin
        IRWre    = 1'b1;
        InsMemRW = 1'b1;
      end
      S_ID: begin
        if (cls == CL_JMP) begin
          PCWre = 1'b1;
          PCSrc = (Op_code == OP_JR) ? 2'b10 : 2'b11;
          // jal links PC+4 into $31 (RegDst 00, WrRegDSrc 0 are the defaults).
          RegWre = (Op_code == OP_JAL);
        end
      end
      S_EXE_AL: begin
        ALUOp   = alu_sel(Op_code);
        ALUSrcA = (Op_code == OP_SLL);
        ALUSrcB = (cls == CL_ALU_I);
        ExtSel  = ~((Op_code == OP_ORI) || (Op_code == OP_SLTIU));
      end
      S_WB_AL: begin
        RegWre    = 1'b1;
        WrRegDSrc = 1'b1;
        RegDst    = (cls == CL_ALU_I) ? 2'b01 : 2'b10;
        PCWre     = 1'b1;
      end
      S_EXE_BR: begin
        ALUOp  = ALU_SUB;
        ExtSel = 1'b1;
        PCWre  = 1'b1;
        PCSrc  = taken ? 2'b01 : 2'b00;
      end
      S_EXE_LS: begin
        ALUOp   = ALU_ADD;
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
      end
      S_MEM: begin
        if (Op_code == OP_LW) begin
          mRD = 1'b1;
        end else begin
          mWR   = 1'b1;
          PCWre = 1'b1;
        end
      end
      S_WB_LD: begin
        mRD       = 1'b1;
        DBDataSrc = 1'b1;
        RegWre    = 1'b1;
        RegDst    = 2'b01;
        WrRegDSrc = 1'b1;
        PCWre     = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - main control FSM of the multi-cycle MIPS-subset CPU
// Purpose: holds the instruction-phase state register and next-state logic;
//   control outputs come from ctrl_decode.
// Ports: CLK, Reset (async active-low), Op_code, zero, sign in;
//   datapath controls and state_out (debug) out.
module multi_cycle_ctrl
  import cpu_defs_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [OP_W-1:0]    Op_code,
  input  logic               zero,
  input  logic               sign,
  output logic               PCWre,
  output logic               IRWre,
  output logic               InsMemRW,
  output logic               RegWre,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               ExtSel,
  output logic [1:0]         RegDst,
  output logic               WrRegDSrc,
  output logic               DBDataSrc,
  output logic               mRD,
  output logic               mWR,
  output logic [1:0]         PCSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [3:0]         state_out
);

  state_e state_q, state_d;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (op_class(Op_code))
          CL_JMP:  state_d = S_IF;
          CL_BR:   state_d = S_EXE_BR;
          CL_LS:   state_d = S_EXE_LS;
          CL_HALT: state_d = S_HALT;
          default: state_d = S_EXE_AL;
        endcase
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_WB_AL:  state_d = S_IF;
      S_EXE_BR: state_d = S_IF;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = (Op_code == OP_LW) ? S_WB_LD : S_IF;
      S_WB_LD:  state_d = S_IF;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IF;
    endcase
  end

  assign state_out = state_q;

  ctrl_decode u_decode (
    .state     (state_q),
    .Op_code   (Op_code),
    .zero      (zero),
    .sign      (sign),
    .PCWre     (PCWre),
    .IRWre     (IRWre),
    .InsMemRW  (InsMemRW),
    .RegWre    (RegWre),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ExtSel    (ExtSel),
    .RegDst    (RegDst),
    .WrRegDSrc (WrRegDSrc),
    .DBDataSrc (DBDataSrc),
    .mRD       (mRD),
    .mWR       (mWR),
    .PCSrc     (PCSrc),
    .ALUOp     (ALUOp)
  );

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - scoreboard testbench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010;
  localparam logic [5:0] OR_ = 6'b010000, AND_ = 6'b010001, ORI = 6'b010010;
  localparam logic [5:0] SLL = 6'b011000, SLT = 6'b100110, SLTIU = 6'b100111;
  localparam logic [5:0] SW = 6'b110000, LW = 6'b110001;
  localparam logic [5:0] BEQ = 6'b110100, BNE = 6'b110101, BLTZ = 6'b110110;
  localparam logic [5:0] J = 6'b111000, JR = 6'b111001, JAL = 6'b111010, HALT = 6'b111111;
  localparam int HALT_N = 12;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] Op_code = 6'b0;
  logic       zero = 1'b0;
  logic       sign = 1'b0;
  logic       PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB, ExtSel;
  logic [1:0] RegDst, PCSrc;
  logic       WrRegDSrc, DBDataSrc, mRD, mWR;
  logic [2:0] ALUOp;
  logic [3:0] state_out;

  multi_cycle_ctrl dut (
    .CLK(CLK), .Reset(Reset), .Op_code(Op_code), .zero(zero), .sign(sign),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .RegDst(RegDst),
    .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR),
    .PCSrc(PCSrc), .ALUOp(ALUOp), .state_out(state_out)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] st;
    logic       pcwre, irwre, imrw, regwre, srca, srcb, ext;
    logic [1:0] regdst;
    logic       wrsrc, dbsrc, mrd, mwr;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
  } ctl_t;

  ctl_t act;
  assign act = {state_out, PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB, ExtSel,
                RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc, ALUOp};

  ctl_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  logic [5:0] op_tab [20] = '{ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT, SLTIU, SW, LW,
                              BEQ, BNE, BLTZ, J, JR, JAL, HALT, 6'b000011, 6'b101010};

  function automatic ctl_t blank(input logic [3:0] st);
    ctl_t c;
    c = '0;
    c.st = st;
    return c;
  endfunction

  function automatic ctl_t fetch_vec();
    ctl_t c;
    c = blank(4'd0);
    c.irwre = 1'b1;
    c.imrw = 1'b1;
    return c;
  endfunction

  task automatic check(input string name, input ctl_t got, input ctl_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (op=%b t=%0t)", name, got, want, Op_code, $time);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  // Reference: the per-cycle control pattern each instruction must produce,
  // written instruction-by-instruction from the ISA's phase rules.
  task automatic model(input logic [5:0] op, input logic z, input logic s,
                       output int n, output bit halted);
    ctl_t c;
    bit   tk;
    exp_q.push_back(fetch_vec());
    n = 1;
    halted = 1'b0;
    case (op)
      J, JR, JAL: begin
        c = blank(4'd1);
        c.pcwre = 1'b1;
        c.pcsrc = (op == JR) ? 2'b10 : 2'b11;
        c.regwre = (op == JAL);
        exp_q.push_back(c);
        n = 2;
      end
      BEQ, BNE, BLTZ: begin
        exp_q.push_back(blank(4'd1));
        tk = (op == BEQ) ? z : (op == BNE) ? !z : s;
        c = blank(4'd5);
        c.aluop = 3'b001; c.ext = 1'b1; c.pcwre = 1'b1;
        c.pcsrc = tk ? 2'b01 : 2'b00;
        exp_q.push_back(c);
        n = 3;
      end
      SW, LW: begin
        exp_q.push_back(blank(4'd1));
        c = blank(4'd2);
        c.srcb = 1'b1; c.ext = 1'b1;
        exp_q.push_back(c);
        c = blank(4'd3);
        if (op == SW) begin c.mwr = 1'b1; c.pcwre = 1'b1; end
        else c.mrd = 1'b1;
        exp_q.push_back(c);
        n = 4;
        if (op == LW) begin
          c = blank(4'd4);
          c.mrd = 1'b1; c.dbsrc = 1'b1; c.regwre = 1'b1; c.regdst = 2'b01;
          c.wrsrc = 1'b1; c.pcwre = 1'b1;
          exp_q.push_back(c);
          n = 5;
        end
      end
      ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT, SLTIU: begin
        exp_q.push_back(blank(4'd1));
        c = blank(4'd6);
        case (op)
          SUB: c.aluop = 3'd1;
          SLL: c.aluop = 3'd2;
          OR_, ORI: c.aluop = 3'd3;
          AND_: c.aluop = 3'd4;
          SLTIU: c.aluop = 3'd5;
          SLT: c.aluop = 3'd6;
          default: c.aluop = 3'd0;
        endcase
        c.srca = (op == SLL);
        c.srcb = (op == ADDI || op == ORI || op == SLTIU);
        c.ext = !(op == ORI || op == SLTIU);
        exp_q.push_back(c);
        c = blank(4'd7);
        c.regwre = 1'b1; c.wrsrc = 1'b1; c.pcwre = 1'b1;
        c.regdst = (op == ADDI || op == ORI || op == SLTIU) ? 2'b01 : 2'b10;
        exp_q.push_back(c);
        n = 4;
      end
      default: begin
        exp_q.push_back(blank(4'd1));
        for (int i = 0; i < HALT_N; i++) exp_q.push_back(blank(4'd8));
        n = 2 + HALT_N;
        halted = 1'b1;
      end
    endcase
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL underflow: got=%h want=none", act);
      end else begin
        check("cycle", act, exp_q.pop_front());
      end
    end
  end

  // Called #1 after a posedge; pulls reset briefly and leaves the FSM in sIF.
  task automatic do_reset();
    mon_en = 1'b0;
    Reset = 1'b0;
    #1;
    check("reset_async", act, fetch_vec());
    #1;
    Reset = 1'b1;
  endtask

  // Called #1 after the posedge that put the FSM in sIF.
  task automatic run_instr(input logic [5:0] op, input logic z, input logic s);
    int n;
    bit h;
    Op_code = op;
    zero = z;
    sign = s;
    model(op, z, s, n, h);
    mon_en = 1'b1;
    if (h) begin
      repeat (3) @(posedge CLK);
      #1;
      Op_code = ORI;
      repeat (n - 3) @(posedge CLK);
      #1;
      do_reset();
    end else begin
      repeat (n) @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", act, fetch_vec());
    Reset = 1'b1;

    // Reset in the middle of an add, while in sEXE_AL.
    Op_code = ADD;
    repeat (2) @(posedge CLK);
    #1;
    check_val("pre_reset_exe_al", int'(state_out), 6);
    Reset = 1'b0;
    #1;
    check("mid_reset", act, fetch_vec());
    #1;
    Reset = 1'b1;
    @(posedge CLK);
    #1;
    check_val("post_reset_id", int'(state_out), 1);
    repeat (3) @(posedge CLK);
    #1;

    run_instr(ADD, 1'b0, 1'b0);
    run_instr(LW, 1'b0, 1'b0);
    run_instr(BEQ, 1'b1, 1'b0);
    run_instr(BEQ, 1'b0, 1'b0);
    run_instr(JAL, 1'b0, 1'b0);
    run_instr(HALT, 1'b0, 1'b0);
    run_instr(BNE, 1'b0, 1'b1);
    run_instr(BLTZ, 1'b0, 1'b1);
    run_instr(SW, 1'b1, 1'b1);

    for (int k = 0; k < 80; k++) begin
      int idx;
      idx = $urandom_range(0, 19);
      run_instr(op_tab[idx], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    mon_en = 1'b0;
    check_val("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS-subset CPU.
- Sequences each instruction through IF/ID/EXE/MEM/WB.
- Drives the instruction-register write enable (IRWre), PC update, register-file, ALU and data-memory controls.
- Decodes Op_code from the instruction register; uses ALU zero/sign flags to resolve branches.

Parameters:
- OP_W, 6, opcode width.
- ALUOP_W, 3, ALU operation select width.

Ports:
- CLK  input  1  system clock; state advances on posedge.
- Reset  input  1  asynchronous, active-low; forces state sIF.
- Op_code  input  6  opcode from instruction register (stable from the negedge of IF onward).
- zero  input  1  ALU result == 0.
- sign  input  1  ALU result MSB.
- PCWre  output  1  PC load enable.
- IRWre  output  1  instruction-register load enable.
- InsMemRW  output  1  instruction-memory read (1 = read).
- RegWre  output  1  register-file write enable.
- ALUSrcA  output  1  0 = rs, 1 = sa (zero-extended).
- ALUSrcB  output  1  0 = rt, 1 = extended immediate.
- ExtSel  output  1  0 = zero-extend, 1 = sign-extend.
- RegDst  output  2  00 = $31, 01 = rt, 10 = rd.
- WrRegDSrc  output  1  0 = PC+4 (jal), 1 = DB.
- DBDataSrc  output  1  0 = ALU result, 1 = memory data.
- mRD  output  1  data-memory read.
- mWR  output  1  data-memory write.
- PCSrc  output  2  00 = PC+4, 01 = PC+4+(imm<<2), 10 = rs (jr), 11 = jump target.
- ALUOp  output  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 101 sltu, 110 slt.
- state_out  output  4  current state, for debug and verification.

Behaviour:
- State register is 4 bits; async clear to sIF when Reset = 0. All outputs are combinational from state + Op_code + flags.
- During reset all outputs are 0, except InsMemRW = 1 and IRWre = 1 (because state = sIF).
- Opcodes:
  - add 000000, sub 000001, addi 000010
  - or 010000, and 010001, ori 010010
  - sll 011000, slt 100110, sltiu 100111
  - sw 110000, lw 110001
  - beq 110100, bne 110101, bltz 110110
  - j 111000, jr 111001, jal 111010
  - halt 111111
- States:
  - sIF: IRWre = 1, InsMemRW = 1. Next state is always sID.
  - sID:
    - j: PCWre = 1, PCSrc = 11, next sIF.
    - jr: PCWre = 1, PCSrc = 10, next sIF.
    - jal: RegWre = 1, RegDst = 00, WrRegDSrc = 0, PCWre = 1, PCSrc = 11, next sIF.
    - halt: next sHALT.
    - beq/bne/bltz: next sEXE_BR.
    - sw/lw: next sEXE_LS.
    - all others: next sEXE_AL.
    - Undefined opcode: treated as halt.
  - sEXE_AL: ALU controls per opcode. Next state is sWB_AL.
  - sWB_AL: RegWre = 1, WrRegDSrc = 1, DBDataSrc = 0; RegDst = 01 for I-type, 10 for R-type; PCWre = 1, PCSrc = 00. Next state is sIF.
  - sEXE_BR: ALUOp = 001 (sub rs − rt; rt = $0 for bltz), ExtSel = 1.
    - Taken when: beq & zero; bne & !zero; bltz & sign.
    - Taken: PCSrc = 01. Not taken: PCSrc = 00.
    - PCWre = 1. Next state is sIF.
  - sEXE_LS: ALUOp = 000, ALUSrcB = 1, ExtSel = 1. Next state is sMEM.
  - sMEM:
    - sw: mWR = 1, PCWre = 1, PCSrc = 00, next sIF.
    - lw: mRD = 1, next sWB_LD.
  - sWB_LD: mRD = 1, DBDataSrc = 1, RegWre = 1, RegDst = 01, WrRegDSrc = 1, PCWre = 1, PCSrc = 00. Next state is sIF.
  - sHALT: all enables 0. Stays in sHALT until Reset is asserted.
- ExtSel is 0 for ori and sltiu, 1 otherwise. ALUSrcA is 1 only for sll.
- Invariants:
  - PCWre is high for exactly one cycle per instruction, and only in that instruction's final state.
  - IRWre is high only in sIF.
  - RegWre, mWR and PCWre are never asserted in sIF or sHALT.
- Latency in cycles:
  - j/jr/jal: 2
  - branch: 3
  - sw: 4
  - R/I ALU: 4
  - lw: 5
- Reset mid-instruction: state returns to sIF immediately and asynchronously; all write enables drop in the same instant.

Decomposition:
- Shared package `cpu_defs_pkg` holds:
  - opcode localparams
  - state encodings (sIF = 0000, sID = 0001, sEXE_AL = 0110, sWB_AL = 0111, sEXE_BR = 0101, sEXE_LS = 0010, sMEM = 0011, sWB_LD = 0100, sHALT = 1000)
  - ALUOp encodings
- Sub-module `ctrl_decode`: purely combinational, Op_code + state + flags → control outputs.
- The top level holds only the state register and next-state logic.

Test Plan:
- Reset pulse low while state = sEXE_AL.
  - Expect state_out = 0000 asynchronously, IRWre = 1, PCWre = 0, RegWre = 0.
  - After Reset rises, the next posedge moves the FSM to sID.
- Op_code = 000000 (add).
  - Expect states IF→ID→EXE_AL→WB_AL→IF.
  - In WB_AL: RegWre = 1, RegDst = 10, PCWre = 1, PCSrc = 00.
  - PCWre is high for exactly 1 cycle out of the 4.
- Op_code = 110001 (lw).
  - Expect a 5-cycle sequence.
  - mRD = 1 in sMEM and sWB_LD; DBDataSrc = 1 and RegDst = 01 in sWB_LD.
  - mWR is never 1.
- Op_code = 110100 (beq).
  - With zero = 1: PCSrc = 01 in sEXE_BR.
  - Rerun with zero = 0: PCSrc = 00.
  - Both cases take 3 cycles with a single PCWre pulse.
- Op_code = 111010 (jal).
  - In sID: RegWre = 1, RegDst = 00, WrRegDSrc = 0, PCSrc = 11, PCWre = 1.
  - Next state is sIF.
- Op_code = 111111, then Op_code = 010010 (ori) while halted.
  - Expect the FSM to stay in sHALT with all enables 0 for 10 or more cycles.
  - Only Reset escapes sHALT.
